// File: rtl/case_9_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake, clock enable
// and wrap/saturate output narrowing. The whole pipe shifts together (no bubble collapse).
module case_9_mul_pipe_hs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int SIGNED_MODE = 1,
  parameter int SAT_MODE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int DW = dout_WIDTH;
  // One bit wider than both product and result so every range compare is exact.
  localparam int EW = ((PW > DW) ? PW : DW) + 1;

  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] SMAX = (ONE <<< (DW - 1)) - ONE;
  localparam logic signed [EW-1:0] SMIN = -(ONE <<< (DW - 1));
  localparam logic signed [EW-1:0] UMAX = (ONE <<< DW) - ONE;

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || ID < 0) begin : g_badParam
    $error("case_9_mul_pipe_hs: NUM_STAGE must be in 1..8");
  end

  function automatic logic [PW-1:0] mulFull(input logic [din0_WIDTH-1:0] a,
                                            input logic [din1_WIDTH-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    if (SIGNED_MODE != 0) begin
      ax = PW'($signed(a));
      bx = PW'($signed(b));
    end else begin
      ax = PW'(a);
      bx = PW'(b);
    end
    return ax * bx;
  endfunction

  // Returns {ovf, dout}; extension falls out of the same range check.
  function automatic logic [DW:0] narrow(input logic [PW-1:0] p);
    logic signed [EW-1:0] pe;
    logic                 ov;
    logic [DW-1:0]        r;
    if (SIGNED_MODE != 0) begin
      pe = EW'($signed(p));
      ov = (pe > SMAX) || (pe < SMIN);
    end else begin
      pe = EW'(p);
      ov = (pe > UMAX);
    end
    r = pe[DW-1:0];
    if ((SAT_MODE != 0) && ov) begin
      if (SIGNED_MODE != 0) r = pe[EW-1] ? SMIN[DW-1:0] : SMAX[DW-1:0];
      else                  r = UMAX[DW-1:0];
    end
    return {ov, r};
  endfunction

  logic                 advance;
  logic [NUM_STAGE-1:0] stageVld_q;
  logic [DW:0]          res_q;
  logic [DW:0]          res_d;

  assign advance = ce & (~out_vld | out_rdy);
  assign in_rdy  = advance;
  assign out_vld = stageVld_q[NUM_STAGE-1];
  assign dout    = res_q[DW-1:0];
  assign ovf     = res_q[DW];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stageVld_q <= '0;
      res_q      <= '0;
    end else if (advance) begin
      stageVld_q[0] <= in_vld & in_rdy;
      for (int i = 1; i < NUM_STAGE; i++) stageVld_q[i] <= stageVld_q[i-1];
      res_q <= res_d;
    end
  end

  if (NUM_STAGE == 1) begin : g_single
    assign res_d = narrow(mulFull(din0, din1));
  end else begin : g_multi
    logic [din0_WIDTH-1:0] opA_q;
    logic [din1_WIDTH-1:0] opB_q;
    logic [PW-1:0]         prod_d;

    assign prod_d = mulFull(opA_q, opB_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        opA_q <= '0;
        opB_q <= '0;
      end else if (advance) begin
        opA_q <= din0;
        opB_q <= din1;
      end
    end

    if (NUM_STAGE == 2) begin : g_direct
      assign res_d = narrow(prod_d);
    end else begin : g_prodPipe
      // Full-width product is carried through the middle stages for retiming.
      logic [PW-1:0] prod_q [NUM_STAGE-2];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE - 2; i++) prod_q[i] <= '0;
        end else if (advance) begin
          prod_q[0] <= prod_d;
          for (int i = 1; i < NUM_STAGE - 2; i++) prod_q[i] <= prod_q[i-1];
        end
      end

      assign res_d = narrow(prod_q[NUM_STAGE-3]);
    end
  end

endmodule

// File: tb/tb_case_9_mul_pipe_hs.sv
// Scoreboard bench for case_9_mul_pipe_hs: five instances (signed/unsigned, wide/narrow,
// wrap/saturate) share stimulus; an integer reference model supplies expected results.
module tb_case_9_mul_pipe_hs;

  localparam int NI = 5;
  localparam int NS = 3;
  localparam int SGN [NI] = '{1, 0, 1, 1, 0};
  localparam int DWS [NI] = '{26, 26, 16, 16, 16};
  localparam int SAT [NI] = '{0, 0, 0, 1, 1};

  logic        ap_clk   = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ce       = 1'b0;
  logic        in_vld   = 1'b0;
  logic        out_rdy  = 1'b0;
  logic [13:0] din0     = '0;
  logic [11:0] din1     = '0;

  logic [NI-1:0] inRdy;
  logic [NI-1:0] outVld;
  logic [NI-1:0] outOvf;
  logic [25:0]   outDout [NI];

  always #5 ap_clk = ~ap_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DWS[g]-1:0] d;
    case_9_mul_pipe_hs #(
      .ID(g), .NUM_STAGE(NS), .din0_WIDTH(14), .din1_WIDTH(12),
      .dout_WIDTH(DWS[g]), .SIGNED_MODE(SGN[g]), .SAT_MODE(SAT[g])
    ) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
      .in_vld(in_vld), .in_rdy(inRdy[g]), .din0(din0), .din1(din1),
      .out_vld(outVld[g]), .out_rdy(out_rdy), .dout(d), .ovf(outOvf[g])
    );
    assign outDout[g] = 26'(d);
  end

  typedef logic [NI-1:0][26:0] expVec_t;
  expVec_t expQ [$];
  int      rdIdx [NI];
  int      checks   = 0;
  int      failures = 0;

  logic [NI-1:0] stallPrev = '0;
  logic [25:0]   prevDout [NI];
  logic [NI-1:0] prevOvf = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Plain integer arithmetic: value range test, then clamp or keep low dw bits.
  function automatic logic [26:0] refModel(input int sgn, input int dw, input int sat,
                                           input logic [13:0] a, input logic [11:0] b);
    longint     av, bv, p, lo, hi, r;
    logic [63:0] rb, mask;
    logic        ov;
    av = sgn != 0 ? longint'($signed(a)) : longint'(a);
    bv = sgn != 0 ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    if (sgn != 0) begin
      hi = (64'sd1 <<< (dw - 1)) - 1;
      lo = -hi - 1;
    end else begin
      lo = 0;
      hi = (64'sd1 <<< dw) - 1;
    end
    ov = (p < lo) || (p > hi);
    r  = (sat != 0 && ov) ? ((p < lo) ? lo : hi) : p;
    mask = (64'd1 << dw) - 64'd1;
    rb   = r & mask;
    return {ov, rb[25:0]};
  endfunction

  function automatic expVec_t expectAll(input logic [13:0] a, input logic [11:0] b);
    expVec_t v;
    for (int i = 0; i < NI; i++) v[i] = refModel(SGN[i], DWS[i], SAT[i], a, b);
    return v;
  endfunction

  function automatic logic [13:0] pickA();
    case ($urandom_range(0, 5))
      0: return 14'h2000;
      1: return 14'h1FFF;
      2: return 14'h0000;
      3: return 14'h3FFF;
      default: return 14'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] pickB();
    case ($urandom_range(0, 5))
      0: return 12'h800;
      1: return 12'h7FF;
      2: return 12'h000;
      3: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic int pending();
    int m = 0;
    for (int i = 0; i < NI; i++) if (expQ.size() - rdIdx[i] > m) m = expQ.size() - rdIdx[i];
    return m;
  endfunction

  // Monitor: every output transfer pops the instance's next expected result.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stallPrev = '0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("in_rdy[%0d]", i), inRdy[i], ce & (~outVld[i] | out_rdy));
        if (stallPrev[i]) begin
          checkOutput($sformatf("stall_vld[%0d]", i), outVld[i], 1);
          checkOutput($sformatf("stall_dout[%0d]", i), outDout[i], prevDout[i]);
          checkOutput($sformatf("stall_ovf[%0d]", i), outOvf[i], prevOvf[i]);
        end
        if (ce && outVld[i] && out_rdy) begin
          if (rdIdx[i] >= expQ.size()) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_out[%0d] actual dout=%0h required no output", i, outDout[i]);
          end else begin
            expVec_t e;
            e = expQ[rdIdx[i]];
            rdIdx[i]++;
            checkOutput($sformatf("dout[%0d]", i), outDout[i], e[i][25:0]);
            checkOutput($sformatf("ovf[%0d]", i), outOvf[i], e[i][26]);
          end
        end
        stallPrev[i] = outVld[i] & ~(ce & out_rdy);
        prevDout[i]  = outDout[i];
        prevOvf[i]   = outOvf[i];
      end
    end
  end

  task automatic drainPipe();
    int n = 0;
    @(posedge ap_clk); #1;
    in_vld = 0; ce = 1; out_rdy = 1;
    while (pending() != 0 && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput("drain_pending", pending(), 0);
  endtask

  // One beat into an empty pipe; measures cycles until out_vld, optional 2-cycle ce gap.
  task automatic singleBeat(input logic [13:0] a, input logic [11:0] b, input bit ceGap,
                            input int expLat, input bit checkVal, input int idx,
                            input logic [25:0] expDout, input logic expOvf);
    int lat = 0;
    bit seen = 0;
    @(posedge ap_clk); #1;
    ce = 1; out_rdy = 1; in_vld = 1; din0 = a; din1 = b;
    @(negedge ap_clk);
    checkOutput("beat_accept", inRdy[0], 1);
    if (inRdy[0]) expQ.push_back(expectAll(a, b));
    while (!seen && lat < 20) begin
      @(posedge ap_clk); #1;
      in_vld = 0;
      ce = !(ceGap && (lat == 0 || lat == 1));
      @(negedge ap_clk);
      lat++;
      seen = outVld[0];
    end
    checkOutput("latency", lat, expLat);
    if (checkVal) begin
      checkOutput($sformatf("plan_dout[%0d]", idx), outDout[idx], expDout);
      checkOutput($sformatf("plan_ovf[%0d]", idx), outOvf[idx], expOvf);
    end
    @(posedge ap_clk); #1;
    ce = 1;
  endtask

  // mode 0: free flow; 1: out_rdy low cycles 4-7; 2: ce low cycles 5-6; 3: random everything.
  task automatic applyStimulus(input int nBeats, input int mode, output int cycles);
    int sent = 0;
    int cyc  = 0;
    bit have = 0;
    while (sent < nBeats && cyc < 2000) begin
      @(posedge ap_clk); #1;
      case (mode)
        1: begin ce = 1; out_rdy = !(cyc >= 4 && cyc <= 7); end
        2: begin ce = !(cyc == 5 || cyc == 6); out_rdy = 1; end
        3: begin ce = ($urandom_range(0, 9) != 0); out_rdy = ($urandom_range(0, 3) != 0); end
        default: begin ce = 1; out_rdy = 1; end
      endcase
      if (!have && (mode != 3 || $urandom_range(0, 3) != 0)) begin
        din0 = pickA();
        din1 = pickB();
        have = 1;
      end
      in_vld = have;
      @(negedge ap_clk);
      if (in_vld && inRdy[0]) begin
        expQ.push_back(expectAll(din0, din1));
        sent++;
        have = 0;
      end
      cyc++;
    end
    checkOutput("stream_sent", sent, nBeats);
    cycles = cyc;
    @(posedge ap_clk); #1;
    in_vld = 0; ce = 1; out_rdy = 1;
  endtask

  task automatic resetMidFlight();
    drainPipe();
    for (int k = 0; k < 3; k++) begin
      @(posedge ap_clk); #1;
      in_vld = 1; din0 = pickA(); din1 = pickB();
      @(negedge ap_clk);
      if (inRdy[0]) expQ.push_back(expectAll(din0, din1));
    end
    @(posedge ap_clk); #1;
    in_vld = 0;
    checkOutput("pre_reset_vld", outVld[0], 1);
    #2 ap_rst_n = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("rst_vld[%0d]", i), outVld[i], 0);
      checkOutput($sformatf("rst_dout[%0d]", i), outDout[i], 0);
      checkOutput($sformatf("rst_ovf[%0d]", i), outOvf[i], 0);
      rdIdx[i] = expQ.size();
    end
    @(negedge ap_clk);
    @(posedge ap_clk); #2;
    ap_rst_n = 1;
    repeat (6) begin
      @(negedge ap_clk);
      checkOutput("post_reset_idle", outVld, 0);
    end
    singleBeat(14'h0007, 12'hFF9, 0, NS, 1, 0, 26'h3FFFFCF, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NI; i++) rdIdx[i] = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset_vld[%0d]", i), outVld[i], 0);
      checkOutput($sformatf("reset_dout[%0d]", i), outDout[i], 0);
      checkOutput($sformatf("reset_ovf[%0d]", i), outOvf[i], 0);
    end
    @(posedge ap_clk); #2;
    ap_rst_n = 1; ce = 1; out_rdy = 1;

    singleBeat(14'h3FFD, 12'h005, 0, NS, 1, 0, 26'h3FFFFF1, 0);
    singleBeat(14'h2000, 12'h800, 0, NS, 1, 0, 26'h1000000, 0);
    singleBeat(14'h3FFF, 12'hFFF, 0, NS, 1, 1, 26'h3FFB001, 0);
    singleBeat(14'h1FFF, 12'h7FF, 0, NS, 1, 2, 26'h000D801, 1);
    singleBeat(14'h1FFF, 12'h7FF, 0, NS, 1, 3, 26'h0007FFF, 1);
    singleBeat(14'h1FFF, 12'h7FF, 0, NS, 1, 4, 26'h000FFFF, 1);
    drainPipe();
    singleBeat(14'h0123, 12'h045, 1, NS + 2, 0, 0, 26'h0, 0);
    drainPipe();

    applyStimulus(10, 0, cyc);
    checkOutput("cycles_free", cyc, 10);
    drainPipe();
    applyStimulus(10, 1, cyc);
    checkOutput("cycles_backpressure", cyc, 14);
    drainPipe();
    applyStimulus(10, 2, cyc);
    checkOutput("cycles_ce_gap", cyc, 12);
    drainPipe();
    applyStimulus(300, 3, cyc);
    drainPipe();

    resetMidFlight();
    drainPipe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
